// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM states, ring geometry and the rotate helper for the line-buffer sequencer.
package conv_pkg;
  typedef enum logic [1:0] {IDLE, FILL, READ, DONE} state_t;
  localparam int NUM_LB = 4;
  localparam int WIN = 3;
  function automatic logic [NUM_LB-1:0] rotl(input logic [NUM_LB-1:0] v, input logic [$clog2(NUM_LB)-1:0] n);
    return (v << n) | (v >> (NUM_LB - int'(n)));
  endfunction
endpackage

// File: rtl/lb_ring_ptr.sv
// lb_ring_ptr: mod-4 ring pointer plus an up/down occupancy counter.
module lb_ring_ptr
  import conv_pkg::*;
#(
  parameter int MAXC = NUM_LB,
  parameter int CW = $clog2(MAXC + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      adv,
  input  logic                      inc,
  input  logic                      dec,
  output logic [$clog2(NUM_LB)-1:0] ptr,
  output logic [CW-1:0]             cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (clr) begin
      ptr <= '0;
      cnt <= '0;
    end else begin
      if (adv) ptr <= ptr + 1'b1;
      cnt <= cnt + CW'(inc) - CW'(dec);
    end
endmodule

// File: rtl/line_buffer_sequencer.sv
// line_buffer_sequencer: write/read sequencing of the four-line-buffer ring feeding the 3x3 window.
// Define LBSEQ_STALL_CNT_EN to add the o_stall_cnt source-stall counter port.
module line_buffer_sequencer
  import conv_pkg::*;
#(
  parameter int ROW = 4,
  parameter int LINES = 6,
  parameter int PWR = 2,
  parameter int PRD = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_pixel_valid,
  output logic                      o_pixel_ready,
  output logic [NUM_LB-1:0]         o_wr_valid,
  output logic [NUM_LB-1:0]         o_rd_en,
  output logic [$clog2(NUM_LB)-1:0] o_rd_base,
  output logic                      o_window_valid,
  input  logic                      i_window_ready,
  output logic                      o_frame_done,
  output logic                      o_busy
`ifdef LBSEQ_STALL_CNT_EN
  ,
  output logic [15:0]               o_stall_cnt
`endif
);
  localparam int WR_BEATS = ROW / PWR;
  localparam int RD_BEATS = (ROW - 2) / PRD;
  localparam int WRW = $clog2(WR_BEATS + 1);
  localparam int RDW = $clog2(RD_BEATS + 1);
  localparam int RWW = $clog2(LINES + 1);
  localparam int AW = $clog2(NUM_LB + 1);
  localparam int WNW = $clog2(LINES - 1);
  state_t                      state;
  logic                        armed;
  logic [WRW-1:0]              wr_beat;
  logic [RDW-1:0]              rd_beat;
  logic [RWW-1:0]              rows_written;
  logic [$clog2(NUM_LB)-1:0]   wr_ptr;
  logic [AW-1:0]               avail, avail_nxt;
  logic [WNW-1:0]              win_rows;
  logic                        accept, wr_last, rd_fire, rd_last, last_row, clr;
  // armed keeps the source throttled while reset is held and for one cycle after release
  assign o_pixel_ready = armed && state != DONE && avail < AW'(NUM_LB) && rows_written < RWW'(LINES);
  assign accept = i_pixel_valid && o_pixel_ready;
  assign wr_last = accept && wr_beat == WRW'(WR_BEATS - 1);
  assign rd_fire = state == READ && i_window_ready;
  assign rd_last = rd_fire && rd_beat == RDW'(RD_BEATS - 1);
  assign last_row = win_rows == WNW'(LINES - 3);
  assign clr = state == DONE;
  assign avail_nxt = avail + AW'(wr_last) - AW'(rd_last);
  assign o_wr_valid = accept ? rotl(NUM_LB'(1), wr_ptr) : '0;
  assign o_rd_en = rd_fire ? rotl(NUM_LB'(7), o_rd_base) : '0;
  assign o_busy = state != IDLE;
  lb_ring_ptr #(.MAXC(NUM_LB)) u_wr (
    .clk(i_clk), .rst_n(i_rst_n), .clr(clr), .adv(wr_last), .inc(wr_last), .dec(rd_last),
    .ptr(wr_ptr), .cnt(avail)
  );
  lb_ring_ptr #(.MAXC(LINES - 2)) u_rd (
    .clk(i_clk), .rst_n(i_rst_n), .clr(clr), .adv(rd_last), .inc(rd_last), .dec(1'b0),
    .ptr(o_rd_base), .cnt(win_rows)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
      wr_beat <= '0;
      rd_beat <= '0;
      rows_written <= '0;
      o_window_valid <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      armed <= 1'b1;
      o_window_valid <= rd_fire;
      o_frame_done <= rd_last && last_row;
      if (accept) wr_beat <= wr_last ? '0 : wr_beat + 1'b1;
      if (rd_fire) rd_beat <= rd_last ? '0 : rd_beat + 1'b1;
      if (clr) rows_written <= '0;
      else if (wr_last) rows_written <= rows_written + 1'b1;
      case (state)
        IDLE: if (accept) state <= FILL;
        FILL: if (avail_nxt >= AW'(WIN)) state <= READ;
        READ: if (rd_last) state <= last_row ? DONE : avail_nxt < AW'(WIN) ? FILL : READ;
        default: state <= IDLE;
      endcase
    end
`ifdef LBSEQ_STALL_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_stall_cnt <= '0;
    else if (state == IDLE && accept) o_stall_cnt <= '0;
    else if (i_pixel_valid && !o_pixel_ready && o_stall_cnt != 16'hFFFF) o_stall_cnt <= o_stall_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_line_buffer_sequencer.sv
// tb_line_buffer_sequencer: scoreboard bench for the line-buffer sequencer (Row=4, Lines=6, Pwr=2, Prd=1).
module tb_line_buffer_sequencer;
  logic clk = 1'b0, rst_n = 1'b1, valid = 1'b0, win_ready = 1'b0;
  logic pixel_ready, window_valid, frame_done, busy;
  logic [3:0] wr_valid, rd_en;
  logic [1:0] rd_base;
`ifdef LBSEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int vectors = 0, miscompares = 0, mode = 0, beat_idx = 0;
  int wr_seen = 0, rd_seen = 0, win_cnt = 0, last_win = 0, done_cnt = 0, cyc = 0, c6 = 0, first_rd = 0;
  logic [3:0] wr_q[$];
  logic [5:0] rd_q[$];
  logic [3:0] wr_tab [12] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h1, 4'h2, 4'h2};
  logic [5:0] rd_tab [8] = '{{2'd0, 4'b0111}, {2'd0, 4'b0111}, {2'd1, 4'b1110}, {2'd1, 4'b1110},
                             {2'd2, 4'b1101}, {2'd2, 4'b1101}, {2'd3, 4'b1011}, {2'd3, 4'b1011}};

  line_buffer_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pixel_valid(valid), .o_pixel_ready(pixel_ready),
    .o_wr_valid(wr_valid), .o_rd_en(rd_en), .o_rd_base(rd_base), .o_window_valid(window_valid),
    .i_window_ready(win_ready), .o_frame_done(frame_done), .o_busy(busy)
`ifdef LBSEQ_STALL_CNT_EN
    , .o_stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 0: window_ready low, 1: high, 2: toggle every cycle
  initial forever begin
    @(negedge clk);
    win_ready = (mode == 2) ? ~win_ready : (mode == 1);
  end

  initial forever begin
    @(negedge clk);
    #4;
    cyc++;
    if (!rst_n) begin
      wr_seen = 0;
      rd_seen = 0;
      win_cnt = 0;
    end else begin
      if (|wr_valid) begin
        wr_seen++;
        if (wr_seen == 6) c6 = cyc;
        if (wr_q.size() == 0) check("wr_unexpected", 32'(wr_valid), 0);
        else check("wr_valid", 32'(wr_valid), 32'(wr_q.pop_front()));
      end
      if (|rd_en) begin
        if (rd_seen == 0) first_rd = cyc;
        rd_seen++;
        if (!win_ready) check("rd_en_while_not_ready", 32'(rd_en), 0);
        if (rd_q.size() == 0) check("rd_unexpected", 32'({rd_base, rd_en}), 0);
        else check("rd_base_rd_en", 32'({rd_base, rd_en}), 32'(rd_q.pop_front()));
      end
      if (window_valid) win_cnt++;
      if (frame_done) begin
        last_win = win_cnt;
        win_cnt = 0;
        wr_seen = 0;
        rd_seen = 0;
        done_cnt++;
      end
    end
  end

  task automatic start_frame();
    beat_idx = 0;
    foreach (rd_tab[i]) rd_q.push_back(rd_tab[i]);
  endtask

  task automatic send_beats(input int n);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 500) begin
      @(negedge clk);
      valid = 1'b1;
      guard++;
      if (pixel_ready) begin
        wr_q.push_back(wr_tab[beat_idx]);
        beat_idx++;
        sent++;
      end
    end
    @(negedge clk);
    valid = 1'b0;
    if (sent < n) check("beat_timeout", sent, n);
  endtask

  task automatic wait_frame(input int target);
    int g = 0;
    while (done_cnt < target && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("frame_done_seen", done_cnt, target);
    repeat (3) @(negedge clk);
    check("busy_after_frame", 32'(busy), 0);
    check("windows_per_frame", last_win, 8);
    check("scoreboard_drained", wr_q.size() + rd_q.size(), 0);
    check("single_frame_done", done_cnt, target);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    valid = 1'b1;
    #2;
    check("rst_pixel_ready", 32'(pixel_ready), 0);
    check("rst_wr_valid", 32'(wr_valid), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_rd_base", 32'(rd_base), 0);
    check("rst_window_valid", 32'(window_valid), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_busy", 32'(busy), 0);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mode = 1;
    start_frame();
    send_beats(12);
    wait_frame(1);
    check("first_read_after_6th_beat", first_rd - c6, 1);
    mode = 0;
    start_frame();
    send_beats(8);
    repeat (3) @(negedge clk);
    check("ring_full_ready", 32'(pixel_ready), 0);
    check("beats_before_full", wr_seen, 8);
    check("no_reads_while_blocked", rd_seen, 0);
`ifdef LBSEQ_STALL_CNT_EN
    repeat (5) begin
      @(negedge clk);
      valid = 1'b1;
    end
    @(negedge clk);
    valid = 1'b0;
    check("stall_cnt", 32'(stall_cnt), 5);
`endif
    mode = 1;
    send_beats(4);
    wait_frame(2);
    mode = 2;
    start_frame();
    send_beats(12);
    wait_frame(3);
    mode = 1;
    start_frame();
    send_beats(7);
    #2 check("busy_mid_read", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_rd_en", 32'(rd_en), 0);
    check("abort_wr_valid", 32'(wr_valid), 0);
    check("abort_window_valid", 32'(window_valid), 0);
    check("abort_pixel_ready", 32'(pixel_ready), 0);
    check("abort_rd_base", 32'(rd_base), 0);
    wr_q.delete();
    rd_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_done_after_abort", done_cnt, 3);
    start_frame();
    send_beats(12);
    wait_frame(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
